// File: rtl/led_frame_scheduler.sv
// Frame controller for one WS2812B cube-face strip: latches orientations, walks the pixels
// through the colour mapper / serializer handshake, then enforces the latch gap.
module led_frame_scheduler #(
    parameter int NUM_LEDS       = 64,
    parameter int LATCH_CYCLES   = 2400,
    parameter int REFRESH_CYCLES = 400000,
    parameter int SER_TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        orient_valid,
    input  logic [31:0] orient_in,
    input  logic        ser_done,
    output logic [7:0]  pix_index,
    output logic [31:0] pix_orient,
    output logic        pix_load,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        pending,
    output logic        mc_done,
    output logic        ser_err
);

    localparam int CNT_MAX = (LATCH_CYCLES > SER_TIMEOUT) ? LATCH_CYCLES : SER_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REF_W   = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;

    localparam logic [7:0]       LAST_IDX     = 8'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST   = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(SER_TIMEOUT - 1);
    localparam logic [REF_W-1:0] REF_MAX      = REF_W'(REFRESH_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t             state_reg,     state_next;
    logic [31:0]        shadow_reg,    shadow_next;
    logic [31:0]        active_reg,    active_next;
    logic               pending_reg,   pending_next;
    logic [7:0]         idx_reg,       idx_next;
    logic [CNT_W-1:0]   cnt_reg,       cnt_next;
    logic [REF_W-1:0]   refresh_reg,   refresh_next;
    logic               mc_done_reg,   mc_done_next;
    logic               ser_err_reg,   ser_err_next;
    logic               frame_err_reg, frame_err_next;
    logic               refresh_due;
    logic               frame_start;
    logic               frame_done_c;

    // Saturated timer doubles as the "refresh due" flag; REFRESH_CYCLES of 0 disables it.
    assign refresh_due = (REFRESH_CYCLES != 0) && (refresh_reg == REF_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            shadow_reg    <= '0;
            active_reg    <= '0;
            pending_reg   <= 1'b0;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            refresh_reg   <= '0;
            mc_done_reg   <= 1'b0;
            ser_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shadow_reg    <= shadow_next;
            active_reg    <= active_next;
            pending_reg   <= pending_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            refresh_reg   <= refresh_next;
            mc_done_reg   <= mc_done_next;
            ser_err_reg   <= ser_err_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shadow_next    = shadow_reg;
        active_next    = active_reg;
        pending_next   = pending_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        mc_done_next   = mc_done_reg;
        ser_err_next   = ser_err_reg;
        frame_err_next = frame_err_reg;
        frame_start    = 1'b0;
        frame_done_c   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable && (pending_reg || refresh_due)) begin
                    frame_start    = 1'b1;
                    state_next     = FETCH;
                    active_next    = shadow_reg;
                    idx_next       = '0;
                    pending_next   = 1'b0;
                    frame_err_next = 1'b0;
                end
            end
            FETCH: begin
                cnt_next   = '0;
                state_next = SEND;
            end
            SEND: begin
                // A ser_done arriving on the timeout cycle still counts as success.
                if (ser_done) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = LATCH;
                        cnt_next   = '0;
                    end else begin
                        idx_next   = idx_reg + 8'd1;
                        state_next = FETCH;
                    end
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    ser_err_next   = 1'b1;
                    frame_err_next = 1'b1;
                    state_next     = LATCH;
                    cnt_next       = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            LATCH: begin
                if (cnt_reg == LATCH_LAST) begin
                    frame_done_c = 1'b1;
                    state_next   = IDLE;
                    mc_done_next = ~pending_reg & ~frame_err_reg;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // A strobe overrides any same-cycle pending clear or completion report.
        if (orient_valid) begin
            shadow_next  = orient_in;
            pending_next = 1'b1;
            mc_done_next = 1'b0;
        end

        refresh_next = refresh_reg;
        if (frame_start) begin
            refresh_next = '0;
        end else if ((state_reg == IDLE) && (refresh_reg != REF_MAX)) begin
            refresh_next = refresh_reg + REF_W'(1);
        end
    end

    assign pix_index  = idx_reg;
    assign pix_orient = active_reg;
    assign pix_load   = (state_reg == FETCH);
    assign frame_busy = (state_reg != IDLE);
    assign frame_done = frame_done_c;
    assign pending    = pending_reg;
    assign mc_done    = mc_done_reg;
    assign ser_err    = ser_err_reg;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler: table-driven first frame plus hand-written
// sequences for late strobes, serializer timeout, periodic refresh and mid-frame reset.
module tb_led_frame_scheduler;

    localparam logic [31:0] V1    = 32'h0029_8960;
    localparam logic [31:0] VA    = 32'h1111_1111;
    localparam logic [31:0] VB    = 32'h0000_0249;
    localparam logic [31:0] C_VAL = 32'h0CCC_0123;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        enable_a = 1'b1, ov_a = 1'b0, ser_done_a;
    logic [31:0] orient_in_a = '0;
    logic [7:0]  pix_index_a;
    logic [31:0] pix_orient_a;
    logic        pix_load_a, frame_busy_a, frame_done_a, pending_a, mc_done_a, ser_err_a;

    logic        enable_b = 1'b0, ov_b = 1'b0, ser_done_b;
    logic [31:0] orient_in_b = '0;
    logic [7:0]  pix_index_b;
    logic [31:0] pix_orient_b;
    logic        pix_load_b, frame_busy_b, frame_done_b, pending_b, mc_done_b, ser_err_b;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int sd_cnt_a = 0, sd_cnt_b = 0;
    logic silent_a = 1'b0;
    int load_cnt_a = 0, done_cnt_a = 0, busy_cnt_a = 0, load_c_cnt_a = 0, load_cnt_b = 0;

    always #5 clk = ~clk;

    led_frame_scheduler #(.NUM_LEDS(4), .LATCH_CYCLES(10), .REFRESH_CYCLES(0), .SER_TIMEOUT(20)) dut (
        .clk(clk), .reset(reset), .enable(enable_a), .orient_valid(ov_a), .orient_in(orient_in_a),
        .ser_done(ser_done_a), .pix_index(pix_index_a), .pix_orient(pix_orient_a),
        .pix_load(pix_load_a), .frame_busy(frame_busy_a), .frame_done(frame_done_a),
        .pending(pending_a), .mc_done(mc_done_a), .ser_err(ser_err_a)
    );

    led_frame_scheduler #(.NUM_LEDS(4), .LATCH_CYCLES(10), .REFRESH_CYCLES(50), .SER_TIMEOUT(20)) dut_r (
        .clk(clk), .reset(reset), .enable(enable_b), .orient_valid(ov_b), .orient_in(orient_in_b),
        .ser_done(ser_done_b), .pix_index(pix_index_b), .pix_orient(pix_orient_b),
        .pix_load(pix_load_b), .frame_busy(frame_busy_b), .frame_done(frame_done_b),
        .pending(pending_b), .mc_done(mc_done_b), .ser_err(ser_err_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer models: ser_done 5 cycles after pix_load; model A can drop pixel 2.
    always @(posedge clk) begin
        ser_done_a <= 1'b0;
        if (sd_cnt_a == 1) begin
            ser_done_a <= 1'b1;
            sd_cnt_a   <= 0;
        end else if (sd_cnt_a > 1) begin
            sd_cnt_a <= sd_cnt_a - 1;
        end
        if (pix_load_a && !(silent_a && pix_index_a == 8'd2)) sd_cnt_a <= 4;
    end

    always @(posedge clk) begin
        ser_done_b <= 1'b0;
        if (sd_cnt_b == 1) begin
            ser_done_b <= 1'b1;
            sd_cnt_b   <= 0;
        end else if (sd_cnt_b > 1) begin
            sd_cnt_b <= sd_cnt_b - 1;
        end
        if (pix_load_b) sd_cnt_b <= 4;
    end

    always @(negedge clk) begin
        if (pix_load_a) load_cnt_a <= load_cnt_a + 1;
        if (pix_load_a && pix_orient_a == C_VAL) load_c_cnt_a <= load_c_cnt_a + 1;
        if (frame_done_a) done_cnt_a <= done_cnt_a + 1;
        if (frame_busy_a) busy_cnt_a <= busy_cnt_a + 1;
        if (pix_load_b) load_cnt_b <= load_cnt_b + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          rel;
        logic        load;
        logic        busy;
        logic        done;
        logic        pend;
        logic        mcd;
        logic [7:0]  idx;
        logic [31:0] orient;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
        end else begin
            $display("ok   %s cycle=%0d value=%h", nm, cyc, act);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic strobe_a(input logic [31:0] v);
        orient_in_a = v;
        ov_a = 1'b1;
        @(negedge clk);
        ov_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] v);
        orient_in_b = v;
        ov_b = 1'b1;
        @(negedge clk);
        ov_b = 1'b0;
    endtask

    initial begin
        int n;
        int s_load, s_done, s_c, s_busy;

        //             rel load busy done pend mcd idx    orient
        tbl[0]  = '{ 1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0};
        tbl[1]  = '{ 2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, V1};
        tbl[2]  = '{ 3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, V1};
        tbl[3]  = '{ 8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, V1};
        tbl[4]  = '{14,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, V1};
        tbl[5]  = '{20,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, V1};
        tbl[6]  = '{25,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, V1};
        tbl[7]  = '{26,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, V1};
        tbl[8]  = '{34,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, V1};
        tbl[9]  = '{35,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, V1};
        tbl[10] = '{36,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, V1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.pix_load",   32'(pix_load_a),   32'h0);
        chk("rst.frame_busy", 32'(frame_busy_a), 32'h0);
        chk("rst.frame_done", 32'(frame_done_a), 32'h0);
        chk("rst.pending",    32'(pending_a),    32'h0);
        chk("rst.mc_done",    32'(mc_done_a),    32'h0);
        chk("rst.ser_err",    32'(ser_err_a),    32'h0);
        chk("rst.pix_index",  32'(pix_index_a),  32'h0);
        chk("rst.pix_orient", pix_orient_a,      32'h0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle.no_start", 32'(frame_busy_a), 32'h0);

        // First frame, table driven
        n = cyc;
        strobe_a(V1);
        for (int i = 0; i < 11; i++) begin
            wait_to(n + tbl[i].rel);
            chk($sformatf("t1.load@%0d", tbl[i].rel),   32'(pix_load_a),   32'(tbl[i].load));
            chk($sformatf("t1.busy@%0d", tbl[i].rel),   32'(frame_busy_a), 32'(tbl[i].busy));
            chk($sformatf("t1.done@%0d", tbl[i].rel),   32'(frame_done_a), 32'(tbl[i].done));
            chk($sformatf("t1.pend@%0d", tbl[i].rel),   32'(pending_a),    32'(tbl[i].pend));
            chk($sformatf("t1.mcdone@%0d", tbl[i].rel), 32'(mc_done_a),    32'(tbl[i].mcd));
            chk($sformatf("t1.index@%0d", tbl[i].rel),  32'(pix_index_a),  32'(tbl[i].idx));
            chk($sformatf("t1.orient@%0d", tbl[i].rel), pix_orient_a,      tbl[i].orient);
        end
        wait_to(n + 45);

        // Late strobe during pixel 1 -> second frame right after frame_done
        n = cyc;
        strobe_a(VA);
        wait_to(n + 9);
        strobe_a(VB);
        chk("t2.orient_held", pix_orient_a, VA);
        chk("t2.pending", 32'(pending_a), 32'h1);
        wait_to(n + 35);
        chk("t2.frame_done", 32'(frame_done_a), 32'h1);
        wait_to(n + 36);
        chk("t2.mc_done_low", 32'(mc_done_a), 32'h0);
        chk("t2.idle_busy", 32'(frame_busy_a), 32'h0);
        wait_to(n + 37);
        chk("t2.reload", 32'(pix_load_a), 32'h1);
        chk("t2.new_orient", pix_orient_a, VB);
        chk("t2.new_index", 32'(pix_index_a), 32'h0);
        wait_to(n + 70);
        chk("t2.frame_done2", 32'(frame_done_a), 32'h1);
        wait_to(n + 71);
        chk("t2.mc_done", 32'(mc_done_a), 32'h1);
        wait_to(n + 80);

        // Three strobes during one frame -> exactly one extra frame showing the last
        s_load = load_cnt_a;
        s_done = done_cnt_a;
        s_c    = load_c_cnt_a;
        n = cyc;
        strobe_a(V1);
        wait_to(n + 5);
        strobe_a(VA);
        wait_to(n + 10);
        strobe_a(VB);
        wait_to(n + 15);
        strobe_a(C_VAL);
        wait_to(n + 120);
        chk("t3.loads", 32'(load_cnt_a - s_load), 32'd8);
        chk("t3.frames", 32'(done_cnt_a - s_done), 32'd2);
        chk("t3.loads_c", 32'(load_c_cnt_a - s_c), 32'd4);
        chk("t3.orient", pix_orient_a, C_VAL);
        chk("t3.pending", 32'(pending_a), 32'h0);
        chk("t3.mc_done", 32'(mc_done_a), 32'h1);

        // Serializer silent on pixel 2 -> timeout, latch, no pixel 3
        silent_a = 1'b1;
        s_load = load_cnt_a;
        n = cyc;
        strobe_a(VB);
        wait_to(n + 14);
        chk("t4.load_px2", 32'(pix_index_a), 32'd2);
        wait_to(n + 34);
        chk("t4.err_before", 32'(ser_err_a), 32'h0);
        wait_to(n + 35);
        chk("t4.ser_err", 32'(ser_err_a), 32'h1);
        chk("t4.latch_busy", 32'(frame_busy_a), 32'h1);
        wait_to(n + 43);
        chk("t4.no_done_early", 32'(frame_done_a), 32'h0);
        wait_to(n + 44);
        chk("t4.frame_done", 32'(frame_done_a), 32'h1);
        wait_to(n + 45);
        chk("t4.mc_done", 32'(mc_done_a), 32'h0);
        chk("t4.idle", 32'(frame_busy_a), 32'h0);
        wait_to(n + 60);
        chk("t4.loads", 32'(load_cnt_a - s_load), 32'd3);
        chk("t4.err_sticky", 32'(ser_err_a), 32'h1);
        silent_a = 1'b0;

        // Periodic refresh on the second instance
        n = cyc;
        strobe_b(V1);
        wait_to(n + 2);
        enable_b = 1'b1;
        wait_to(n + 3);
        chk("t5.load", 32'(pix_load_b), 32'h1);
        chk("t5.orient", pix_orient_b, V1);
        chk("t5.pending", 32'(pending_b), 32'h0);
        wait_to(n + 37);
        chk("t5.mc_done", 32'(mc_done_b), 32'h1);
        wait_to(n + 87);
        chk("t5.wait_refresh", 32'(frame_busy_b), 32'h0);
        wait_to(n + 88);
        chk("t5.refresh_load", 32'(pix_load_b), 32'h1);
        chk("t5.refresh_index", 32'(pix_index_b), 32'h0);
        chk("t5.refresh_orient", pix_orient_b, V1);
        wait_to(n + 125);
        enable_b = 1'b0;
        wait_to(n + 260);
        chk("t5.loads", 32'(load_cnt_b), 32'd8);
        chk("t5.idle", 32'(frame_busy_b), 32'h0);

        // Reset dropped while pixel 2 is being fetched
        n = cyc;
        strobe_a(VA);
        wait_to(n + 14);
        chk("t6.pre_load", 32'(pix_load_a), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("t6.pix_load", 32'(pix_load_a), 32'h0);
        chk("t6.frame_busy", 32'(frame_busy_a), 32'h0);
        chk("t6.pix_index", 32'(pix_index_a), 32'h0);
        chk("t6.pix_orient", pix_orient_a, 32'h0);
        chk("t6.pending", 32'(pending_a), 32'h0);
        chk("t6.ser_err", 32'(ser_err_a), 32'h0);
        chk("t6.mc_done", 32'(mc_done_a), 32'h0);
        chk("t6.frame_done", 32'(frame_done_a), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        enable_a = 1'b1;
        s_busy = busy_cnt_a;
        s_load = load_cnt_a;
        n = cyc;
        wait_to(n + 40);
        chk("t6.no_resume_busy", 32'(busy_cnt_a - s_busy), 32'd0);
        chk("t6.no_resume_load", 32'(load_cnt_a - s_load), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Frame-level controller for the WS2812B LED strip that displays one cube face. It holds a double-buffered 32-bit face orientation from the SPI side and walks the strip pixel by pixel. For each pixel it drives the index/orientation consumed by the combinational colour mapper, then hands off to the 24-bit serializer with a load/done handshake. After the last pixel it enforces the strip latch gap, then reports completion back to the microcontroller; periodic refresh and late orientation updates are arbitrated at frame boundaries.

## Interface
- NUM_LEDS, 64: pixels per frame (2..256).
- LATCH_CYCLES, 2400: low-time after last pixel before frame_done (60 us at 40 MHz).
- REFRESH_CYCLES, 400000: idle cycles after frame_done before an automatic resend; 0 disables refresh.
- SER_TIMEOUT, 4096: max cycles waiting for ser_done per pixel.
- clk  in  1  system clock (40 MHz).
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- enable  in  1  permits new frames to start; never aborts a running frame.
- orient_valid  in  1  single-cycle strobe; orient_in valid this cycle.
- orient_in  in  32  new orientation (3 bits per square, squares 1-9 in [26:0]).
- ser_done  in  1  single-cycle pulse from the serializer: 24 bits sent.
- pix_index  out  8  current pixel, 0..NUM_LEDS-1.
- pix_orient  out  32  active-frame orientation, stable for the whole frame.
- pix_load  out  1  one-cycle pulse: serializer samples mapper colour and starts.
- frame_busy  out  1  high from frame start through end of latch gap.
- frame_done  out  1  one-cycle pulse at end of latch gap.
- pending  out  1  shadow orientation not yet displayed.
- mc_done  out  1  level: latest orientation fully displayed and latched.
- ser_err  out  1  sticky: a serializer timeout occurred.

## Operation
- Registers: shadow[31:0], active (= pix_orient), pending, pix_index, latch/timeout counter, refresh timer, state.
- orient_valid (any state): shadow <= orient_in, pending <= 1, mc_done <= 0. Multiple strobes before a frame start: last value wins.
- States: IDLE, FETCH, SEND, LATCH.
- IDLE: if enable & (pending | refresh_due) -> FETCH; active <= shadow; pix_index <= 0; pending <= 0 unless orient_valid is also high that cycle, in which case shadow takes the new value and pending stays 1.
- refresh_due: refresh timer == REFRESH_CYCLES (nonzero). Timer counts only in IDLE, saturates, and clears at frame start. Pending and refresh_due together start exactly one frame.
- FETCH: pix_load = 1 (Moore, exactly one cycle); -> SEND; timeout counter <= 0.
- SEND: on ser_done: if pix_index == NUM_LEDS-1 -> LATCH, counter <= 0; otherwise pix_index++ and -> FETCH. ser_done outside SEND is ignored.
- SEND timeout: if the counter reaches SER_TIMEOUT-1 without ser_done: ser_err <= 1, -> LATCH (remaining pixels skipped).
- LATCH: count to LATCH_CYCLES-1, then frame_done = 1 for one cycle, -> IDLE. mc_done <= ~pending & ~ser_err-of-this-frame on that cycle.
- frame_busy = (state != IDLE).
- pix_index holds its last value in LATCH and IDLE until the next start.
- enable low mid-frame: frame completes normally; IDLE then holds.
- Reset values: state IDLE; all outputs 0; shadow, active and counters 0.

## Timing
- orient_valid at cycle N (state IDLE, enable = 1): pending = 1 at N+1; FETCH/pix_load at N+2; pix_orient updated at N+2.
- Mapper colour must be valid in the FETCH cycle (pix_index registered since FETCH entry).
- Pixel period = 1 (FETCH) + cycles to ser_done + 1 (the ser_done cycle itself in SEND).
- Frame length = sum of pixel periods + LATCH_CYCLES. frame_done fires LATCH_CYCLES cycles after LATCH entry; IDLE is reached on the following cycle.
- Earliest back-to-back frame start: the cycle after frame_done.
- Reset mid-frame: pix_load and frame_busy drop asynchronously; no partial frame resumes.

## Test plan
Bench parameters: NUM_LEDS=4, LATCH_CYCLES=10, REFRESH_CYCLES=0, SER_TIMEOUT=20. Serializer model returns ser_done 5 cycles after pix_load.
- Strobe orient_in=32'h0029_8960 at cycle 0 -> pix_load at cycle 2 with pix_index 0,1,2,3 at 6-cycle spacing; frame_done once, 10 cycles after the 4th ser_done; mc_done=1; pix_orient=32'h0029_8960.
- Strobe 32'h0000_0249 during pixel 1 -> pix_orient unchanged, pending=1, mc_done=0 at frame_done; second frame starts the cycle after frame_done with the new value; then mc_done=1.
- Three strobes (A, B, C) during one frame -> exactly one extra frame, showing C.
- Serializer model silent on pixel 2 -> ser_err=1 at 20 cycles into SEND; LATCH 10 cycles; frame_done pulse; mc_done=0; pixel 3 never loaded.
- REFRESH_CYCLES=50, no strobes after the first frame -> a new frame starts 50 cycles after IDLE entry, repeating with the same orientation; enable=0 -> no further starts.
- Drop reset during pixel 2 -> all outputs 0 immediately. After release with enable=1 and no strobe, frame_busy stays 0.
